// File: rtl/ntt_seq_ctrl.sv
// Serial N-point naive NTT controller: load N coefficients, evaluate X[k] on one modular MAC, stream results out.
// Optional build macro NTT_BITREV_OUT_EN: emit results in bit-reversed index order.
module ntt_seq_ctrl #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         cfg_omega,
    input  logic [W-1:0]         cfg_mod,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 busy,
    output logic                 err
);

    localparam int LOGN = $clog2(N);
    localparam int W2   = 2 * W;
    localparam int W2P  = 2 * W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] EMIT = 2'd3;

    localparam logic [LOGN-1:0] LAST   = LOGN'(N - 1);
    localparam logic [LOGN-1:0] ONE_L  = LOGN'(1);
    localparam logic [LOGN-1:0] ZERO_L = LOGN'(0);
    localparam logic [W-1:0]    ZERO_W = W'(0);
    localparam logic [W-1:0]    ONE_W  = W'(1);
    localparam logic [W-1:0]    TWO_W  = W'(2);

`ifdef NTT_BITREV_OUT_EN
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        r = ZERO_L;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = x[LOGN-1-i];
        end
        return r;
    endfunction
`endif

    function automatic logic [LOGN-1:0] emit_map(input logic [LOGN-1:0] e);
`ifdef NTT_BITREV_OUT_EN
        return bitrev(e);
`else
        return e;
`endif
    endfunction

    logic [1:0]      state_r;
    logic [W-1:0]    omega_r;
    logic [W-1:0]    q_r;
    logic            err_r;
    logic [LOGN-1:0] j_r;
    logic [LOGN-1:0] k_r;
    logic [LOGN-1:0] e_r;
    logic [W-1:0]    acc_r;
    logic [W-1:0]    tw_r;
    logic [W-1:0]    step_r;
    logic [W-1:0]    a_mem_r   [N];
    logic [W-1:0]    res_mem_r [N];
    logic            in_ready_r;
    logic            out_valid_r;
    logic [W-1:0]    out_data_r;
    logic [LOGN-1:0] out_idx_r;
    logic            busy_r;

    logic            in_hs_s;
    logic            out_hs_s;
    logic [W-1:0]    q_sel_s;
    logic            q_small_s;
    logic [W-1:0]    q_div_s;
    logic [W-1:0]    in_mod_s;
    logic [W2-1:0]   prod_s;
    logic [W2P-1:0]  sum_s;
    logic [W-1:0]    acc_n_s;
    logic [W-1:0]    tw_n_s;
    logic [W-1:0]    step_n_s;
    logic [LOGN-1:0] e_nxt_s;

    // Modular datapath; q<2 frames use a dummy divisor of 2 and force results to zero.
    always_comb begin
        q_sel_s   = (state_r == IDLE) ? cfg_mod : q_r;
        q_small_s = (q_sel_s < TWO_W);
        q_div_s   = q_small_s ? TWO_W : q_sel_s;
        if (q_small_s) begin
            in_mod_s = ZERO_W;
        end else begin
            in_mod_s = in_data % q_div_s;
        end
        prod_s = W2'(a_mem_r[j_r]) * W2'(tw_r);
        sum_s  = W2P'(prod_s) + W2P'(acc_r);
        if (err_r) begin
            acc_n_s = ZERO_W;
        end else begin
            acc_n_s = W'(sum_s % W2P'(q_div_s));
        end
        tw_n_s   = W'((W2'(tw_r) * W2'(step_r)) % W2'(q_div_s));
        step_n_s = W'((W2'(step_r) * W2'(omega_r)) % W2'(q_div_s));
        in_hs_s  = in_valid & in_ready_r;
        out_hs_s = out_valid_r & out_ready;
        e_nxt_s  = e_r + ONE_L;
    end

    // Frame sequencer: load, N*N MAC cycles, then registered result emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            omega_r     <= ZERO_W;
            q_r         <= ZERO_W;
            err_r       <= 1'b0;
            j_r         <= ZERO_L;
            k_r         <= ZERO_L;
            e_r         <= ZERO_L;
            acc_r       <= ZERO_W;
            tw_r        <= ZERO_W;
            step_r      <= ZERO_W;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= ZERO_W;
            out_idx_r   <= ZERO_L;
            busy_r      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_mem_r[i]   <= ZERO_W;
                res_mem_r[i] <= ZERO_W;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_hs_s) begin
                        omega_r    <= cfg_omega;
                        q_r        <= cfg_mod;
                        err_r      <= q_small_s;
                        a_mem_r[0] <= in_mod_s;
                        j_r        <= ONE_L;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs_s) begin
                        a_mem_r[j_r] <= in_mod_s;
                        if (j_r == LAST) begin
                            in_ready_r <= 1'b0;
                            j_r        <= ZERO_L;
                            k_r        <= ZERO_L;
                            acc_r      <= ZERO_W;
                            tw_r       <= ONE_W;
                            step_r     <= ONE_W;
                            state_r    <= CALC;
                        end else begin
                            j_r <= j_r + ONE_L;
                        end
                    end
                end
                CALC: begin
                    if (j_r == LAST) begin
                        res_mem_r[k_r] <= acc_n_s;
                        acc_r          <= ZERO_W;
                        tw_r           <= ONE_W;
                        step_r         <= step_n_s;
                        j_r            <= ZERO_L;
                        if (k_r == LAST) begin
                            k_r     <= ZERO_L;
                            e_r     <= ZERO_L;
                            state_r <= EMIT;
                        end else begin
                            k_r <= k_r + ONE_L;
                        end
                    end else begin
                        acc_r <= acc_n_s;
                        tw_r  <= tw_n_s;
                        j_r   <= j_r + ONE_L;
                    end
                end
                EMIT: begin
                    // First EMIT cycle only primes the output register.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= res_mem_r[emit_map(e_r)];
                        out_idx_r   <= emit_map(e_r);
                    end else if (out_hs_s) begin
                        if (e_r == LAST) begin
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            e_r         <= ZERO_L;
                            state_r     <= IDLE;
                        end else begin
                            e_r        <= e_nxt_s;
                            out_data_r <= res_mem_r[emit_map(e_nxt_s)];
                            out_idx_r  <= emit_map(e_nxt_s);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed self-checking bench for ntt_seq_ctrl (N=8, W=8), natural or bit-reversed emission.
module tb_ntt_seq_ctrl;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int LOGN = 3;

    typedef logic [W-1:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    cfg_omega = 8'd0;
    logic [W-1:0]    cfg_mod = 8'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = 8'd0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [LOGN-1:0] out_idx;
    logic            busy;
    logic            err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int hs_cyc = 0;

    vec_t a_basic  = '{8'd3, 8'd1, 8'd2, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    vec_t a_big    = '{8'd20, 8'd18, 8'd19, 8'd23, 8'd17, 8'd0, 8'd0, 8'd0};
    vec_t a_ones   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    vec_t x_basic  = '{8'd12, 8'd9, 8'd4, 8'd12, 8'd15, 8'd15, 8'd15, 8'd10};
    vec_t x_ones   = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vec_t x_zero   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    ntt_seq_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_omega (cfg_omega),
        .cfg_mod   (cfg_mod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [LOGN-1:0] emit_pos(input int n);
        logic [LOGN-1:0] v;
        v = n[LOGN-1:0];
`ifdef NTT_BITREV_OUT_EN
        return {v[0], v[1], v[2]};
`else
        return v;
`endif
    endfunction

    task automatic send_frame(input vec_t av, input logic [W-1:0] om, input logic [W-1:0] q, input bit gaps);
        int t;
        cfg_omega = om;
        cfg_mod   = q;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = av[i];
            t = 0;
            while (in_ready !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout: coef %0d in_ready=%b expected 1", i, in_ready);
            end
            @(negedge clk);
            if (i == 0) begin
                cfg_omega = 8'hA5;
                cfg_mod   = 8'h03;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        hs_cyc   = cyc;
    endtask

    task automatic recv_frame(input vec_t xv, input bit stall, input logic exp_err, input string name);
        int t;
        int lat;
        int bad_calc;
        int stall_bad;
        bit rdy;
        logic [LOGN-1:0] p;
        t = 0;
        bad_calc = 0;
        stall_bad = 0;
        while (out_valid !== 1'b1 && t < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad_calc++;
            @(negedge clk);
            t++;
        end
        lat = cyc - hs_cyc;
        tests_run++;
        if (lat !== N * N + 1) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, N * N + 1);
        end
        tests_run++;
        if (bad_calc != 0) begin
            tests_failed++;
            $display("FAIL %s calc_flags: %0d cycles with in_ready!=0 or busy!=1, expected 0", name, bad_calc);
        end
        tests_run++;
        if (err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s err: got %b expected %b", name, err, exp_err);
        end
        for (int n = 0; n < N; n++) begin
            p = emit_pos(n);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== xv[p] || out_idx !== p || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s out[%0d]: valid=%b data=%0d idx=%0d in_ready=%b expected 1/%0d/%0d/0",
                         name, n, out_valid, out_data, out_idx, in_ready, xv[p], p);
            end
            t = 0;
            do begin
                rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                out_ready = rdy;
                @(negedge clk);
                t++;
                if (!rdy) begin
                    if (out_valid !== 1'b1 || out_data !== xv[p] || out_idx !== p || in_ready !== 1'b0) stall_bad++;
                end
            end while (!rdy && t < 50);
        end
        out_ready = 1'b1;
        if (stall) begin
            tests_run++;
            if (stall_bad != 0) begin
                tests_failed++;
                $display("FAIL %s stall_hold: %0d unstable stalled cycles, expected 0", name, stall_bad);
            end
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s end_state: out_valid=%b in_ready=%b busy=%b expected 0/1/0", name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: in_ready=%b out_valid=%b data=%0d idx=%0d busy=%b err=%b expected 1/0/0/0/0/0",
                     in_ready, out_valid, out_data, out_idx, busy, err);
        end
    endtask

    task automatic test_basic();
        send_frame(a_basic, 8'd9, 8'd17, 1'b0);
        recv_frame(x_basic, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_reduce();
        send_frame(a_big, 8'd9, 8'd17, 1'b0);
        recv_frame(x_basic, 1'b0, 1'b0, "reduce");
        send_frame(a_ones, 8'd9, 8'd17, 1'b0);
        recv_frame(x_ones, 1'b0, 1'b0, "ones");
    endtask

    task automatic test_stall();
        send_frame(a_basic, 8'd9, 8'd17, 1'b1);
        recv_frame(x_basic, 1'b1, 1'b0, "stall");
    endtask

    task automatic test_err();
        send_frame(a_basic, 8'd9, 8'd1, 1'b0);
        recv_frame(x_zero, 1'b0, 1'b1, "err_q1");
        repeat (2) @(negedge clk);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_hold: err=%b expected 1", err);
        end
        send_frame(a_basic, 8'd9, 8'd17, 1'b0);
        recv_frame(x_basic, 1'b0, 1'b0, "err_clear");
    endtask

    task automatic test_abort();
        send_frame(a_basic, 8'd9, 8'd17, 1'b0);
        repeat (3 * N + 2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pre: busy=%b in_ready=%b out_valid=%b expected 1/0/0", busy, in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b data=%0d idx=%0d busy=%b err=%b expected 1/0/0/0/0/0",
                     in_ready, out_valid, out_data, out_idx, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(a_basic, 8'd9, 8'd17, 1'b0);
        recv_frame(x_basic, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        send_frame(a_ones, 8'd9, 8'd17, 1'b0);
        recv_frame(x_ones, 1'b0, 1'b0, "b2b_first");
        send_frame(a_basic, 8'd9, 8'd17, 1'b0);
        recv_frame(x_basic, 1'b0, 1'b0, "b2b_second");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_reduce();
        test_stall();
        test_err();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ntt_seq_ctrl.md
Name: ntt_seq_ctrl

Overview:
- Sequencing controller for an N-point naive NTT: X[k] = sum_j a[j]*omega^(j*k) mod q.
- Evaluates the transform serially on one shared modular multiply-accumulate datapath instead of N*N parallel multipliers.
- Accepts coefficients on a valid/ready input stream and computes all N outputs into a result buffer.
- Emits the results on a valid/ready output stream. Sits between the coefficient source and the downstream polynomial pipeline.

Parameters:
- N, 8, transform length; power of two, 2..64; LOGN = clog2(N) derived internally.
- W, 8, coefficient, omega and modulus width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_omega  input  W  primitive N-th root of unity; sampled on first input handshake of a frame.
- cfg_mod  input  W  modulus q; sampled with cfg_omega.
- in_valid  input  1  coefficient valid.
- in_ready  output  1  block can accept a coefficient.
- in_data  input  W  coefficient a[j], in index order j = 0..N-1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  result X[k].
- out_idx  output  LOGN  k of the current out_data.
- busy  output  1  high in LOAD, CALC and EMIT.
- err  output  1  frame's sampled q < 2; cleared on the next frame's first input handshake.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE. All counters, buffers, accumulator and config registers are 0.
  - in_ready=1, out_valid=0, out_data=0, out_idx=0, busy=0, err=0.
- A handshake occurs on the rising edge where valid and ready are both 1.
- IDLE: in_ready=1.
  - First input handshake: latch omega and q; store a[0] = in_data mod q; j=1; go to LOAD.
  - Also set err = (q<2) at this handshake.
- LOAD: in_ready=1.
  - Each handshake stores a[j] = in_data mod q and increments j.
  - The handshake with j=N-1 goes to CALC.
  - Gaps in in_valid stall LOAD indefinitely.
- CALC: in_ready=0; runs exactly N*N cycles with one MAC per cycle, k outer loop, j inner loop.
  - Registers: acc, tw (=omega^(j*k) mod q), step (=omega^k mod q).
  - Entry values: acc=0, tw=1, step=1, k=0, j=0.
  - Each cycle: acc_n = (acc + a[j]*tw) mod q, computed at full width (2W+1 bits) before reduction; tw <= tw*step mod q; j++.
  - When j=N-1: write res[k] = acc_n; then acc=0, tw=1, step = step*omega mod q, j=0, k++.
  - After the k=N-1, j=N-1 cycle, go to EMIT.
  - If err=1, all results are written as 0; no modulo by 0/1 is evaluated.
- EMIT: out_valid=1 with out_data=res[e] and out_idx=e, all registered.
  - e advances on each output handshake; out_data/out_idx hold stable while out_ready=0.
  - Handshake on the last entry: out_valid=0, go to IDLE.
  - in_ready=0 throughout EMIT; no overlap with the next frame.
- Latency: out_valid first rises N*N+1 rising edges after the edge accepting a[N-1] (65 for N=8). Throughput is one frame per N*N+2N+1 cycles minimum.
- Assertion of rst_n=0 in any state aborts the frame immediately; all outputs return to reset values and partial results are discarded.
- cfg_omega and cfg_mod changes after the first handshake of a frame have no effect until the next frame.
- Operands must not depend on omega order; the block performs no check that omega is a true N-th root.

Optional Feature:
- NTT_BITREV_OUT_EN
  - Defined: EMIT reads the result buffer in bit-reversed order. Output entry e carries res[bitrev(e)], and out_idx = bitrev(e) (N=8 sequence 0,4,2,6,1,5,3,7).
  - Undefined: natural order, res[e] with out_idx = e.
  - Computation and timing are identical in both cases.

Test Plan:
- N=8, omega=9, q=17, a=[3,1,2,6,0,0,0,0], out_ready=1 -> X=[12,9,4,12,15,15,15,10]; out_idx 0..7; first out_valid 65 cycles after last input handshake; err=0.
- Same frame with NTT_BITREV_OUT_EN -> out_data 12,15,4,15,9,15,12,10 with out_idx 0,4,2,6,1,5,3,7.
- a=[20,18,19,23,17,0,0,0], omega=9, q=17 -> inputs reduced to [3,1,2,6,0,...]; X identical to the first test. Separately, a=[1]*8 -> X=[8,0,0,0,0,0,0,0].
- Random in_valid gaps plus out_ready toggling 1-of-3 cycles -> same X values; out_data/out_idx stable while stalled; in_ready=0 in CALC/EMIT.
- q=1 -> err=1, all eight outputs 0; next frame with q=17 clears err and yields correct X.
- rst_n pulsed low mid-CALC (k=3) -> outputs at reset values asynchronously; next full frame yields the correct X with no leftover state.
